uart_freq_rx_mc: RTL
====================

// Module: uart_freq_rx_mc
// PURPOSE
//  Parametrised UART receiver that loads frequency tuning words into NUM_CH DDS channels.
//  A packet is one header byte (channel select) followed by WORD_BYTES data bytes, LSB byte first.
//  The assembled word is committed atomically to the addressed channel register.
//  Sits between the host serial pin and the phase accumulators.
//  Supports optional parity, framing/header checks and an inter-byte timeout.
// PARAMETERS
//  CLK_DIV       521  clock cycles per UART bit (60 MHz / 115200); must be >= 4
//  NUM_CH        2    number of frequency channels, 1..16
//  WORD_BYTES    2    bytes per frequency word; WORD_W = 8*WORD_BYTES
//  PARITY_EN     0    1: a parity bit follows the 8 data bits
//  PARITY_ODD    0    1: odd parity, 0: even parity (only used when PARITY_EN=1)
//  TIMEOUT_BITS  32   maximum idle gap in bit times between bytes of one packet
// PORTS
//  clk        in   1               system clock
//  rst        in   1               synchronous, active-high reset
//  rx         in   1               asynchronous UART line, idle high
//  freq       out  NUM_CH*WORD_W   channel words; channel k occupies [k*WORD_W +: WORD_W]
//  done       out  1               1-cycle pulse when a word is committed
//  done_ch    out  4               channel index of the last commit; holds until the next commit
//  frame_err  out  1               1-cycle pulse: bad stop bit or bad parity
//  hdr_err    out  1               1-cycle pulse: invalid header byte
//  timeout    out  1               1-cycle pulse: packet abandoned because of an inter-byte gap
//  busy       out  1               high while a packet is in progress (header accepted, not yet committed)
// BEHAVIOUR
//  Reset: all freq words 0, done_ch 0, every pulse output 0, busy 0, both FSMs idle, rx synchroniser set to 1.
//  rx passes through a 2-flop synchroniser; every reference to rx below means the synchronised value.
//  Bit FSM (per byte): IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: clear the counter; on rx==0, go to START.
//   START: count to (CLK_DIV-1)/2, then sample. If rx==0, go to DATA with counter 0; if rx==1, treat as a glitch and return to IDLE (no error).
//   DATA: every CLK_DIV cycles, sample one bit into the shift register, LSB first; after 8 bits, go to PARITY if PARITY_EN, else STOP.
//   PARITY: after CLK_DIV cycles, sample; check against the data XOR (XNOR when PARITY_ODD).
//   STOP: after CLK_DIV cycles, sample. rx==1 and parity OK -> the byte is valid. Otherwise pulse frame_err.
//   The bit FSM returns to IDLE on the same cycle as the stop sample; there is no dead cycle, so back-to-back frames are accepted.
//  Packet FSM: HDR -> DATA(n = 0..WORD_BYTES-1) -> commit -> HDR.
//   HDR: a valid byte with bit7==1 and bits[3:0] < NUM_CH latches the channel and raises busy. Any other value pulses hdr_err and stays in HDR.
//   DATA: each valid byte is written into staging byte n. The freq outputs do not change during this phase.
//   Last byte: on the next clk edge the whole staging word is copied into channel ch, done pulses high for 1 cycle, done_ch <= ch, busy <= 0.
//   A frame_err during a packet abandons the packet (the staged word is discarded) and returns to HDR.
//   Timeout: while busy and the bit FSM is IDLE, a gap counter runs. When it reaches TIMEOUT_BITS*CLK_DIV, pulse timeout, drop the packet and return to HDR. Any start edge clears the gap counter.
//   Any discarded or aborted packet leaves all freq words unchanged. Only one error pulse is asserted per event.
//  rst asserted mid-frame or mid-packet: everything returns to its reset value on the next edge, including freq.
//  Channel registers not addressed by a commit hold their values.
//  Latency: done is asserted 1 cycle after the centre of the last stop bit, plus the 2-cycle synchroniser delay.
// TESTING (bench: CLK_DIV=16, NUM_CH=4, WORD_BYTES=2 unless noted)
//  1. Send 0x82,0x34,0x12 -> one done pulse, done_ch=2, freq[47:32]=0x1234, other channels remain 0.
//  2. Send 0x81,0xCD,0xAB then 0x80,0x01,0x00 back-to-back with no idle gap -> ch1=0xABCD and ch0=0x0001, two done pulses.
//  3. Send 0x85 (channel >= NUM_CH), then 0x12 -> two hdr_err pulses, no done, all freq unchanged.
//  4. Send 0x80,0x55 then wait 40 bit times, then 0x66 -> timeout pulse, no commit; the 0x66 is then treated as a header and rejected with hdr_err.
//  5. Send 0x81,0x11 with stop bit forced to 0 -> frame_err pulse, busy drops, ch1 unchanged.
//  6. PARITY_EN=1, PARITY_ODD=1: a bad parity bit on a data byte gives frame_err; a 1-cycle rx low glitch gives no activity; asserting rst mid-byte clears freq to 0.

Source files
------------

// File: rtl/uart_freq_rx_mc_if.sv
// Bus between the UART frequency-word receiver and its neighbours: the serial
// line coming in and the channel words plus status pulses going out.
interface uart_freq_rx_mc_if #(
  parameter int NUM_CH     = 2,
  parameter int WORD_BYTES = 2
);
  localparam int WORD_W = 8 * WORD_BYTES;

  logic                     rx;
  logic [NUM_CH*WORD_W-1:0] freq;
  logic                     done;
  logic [3:0]               done_ch;
  logic                     frame_err;
  logic                     hdr_err;
  logic                     timeout;
  logic                     busy;

  // Receiver side: consumes the serial line, produces words and status.
  modport master (
    input  rx,
    output freq, done, done_ch, frame_err, hdr_err, timeout, busy
  );

  // Host / DDS side: drives the serial line, consumes words and status.
  modport slave (
    output rx,
    input  freq, done, done_ch, frame_err, hdr_err, timeout, busy
  );
endinterface

// File: rtl/uart_freq_rx_mc.sv
// UART receiver that assembles frequency tuning words for NUM_CH DDS channels.
// A packet is a header byte (bit7 set, channel in bits[3:0]) followed by
// WORD_BYTES data bytes, LSB byte first. The word is committed atomically.
module uart_freq_rx_mc #(
  parameter int CLK_DIV      = 521,
  parameter int NUM_CH       = 2,
  parameter int WORD_BYTES   = 2,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  uart_freq_rx_mc_if.master bus
);
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int LIMIT  = TIMEOUT_BITS * CLK_DIV;
  localparam int GAP_W  = $clog2(LIMIT + 1);

  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLK_DIV - 1) / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LIMIT - 1);
  localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);

  typedef enum logic [2:0] {
    B_IDLE   = 3'd0,
    B_START  = 3'd1,
    B_DATA   = 3'd2,
    B_PARITY = 3'd3,
    B_STOP   = 3'd4
  } bit_state_t;

  typedef enum logic [0:0] {
    P_HDR  = 1'b0,
    P_DATA = 1'b1
  } pkt_state_t;

  // Expected parity bit for a data byte: XOR for even, XNOR for odd.
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    logic p;
    p = ^d;
    if (odd) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

  logic                     rx_meta_r;
  logic                     rx_sync_r;
  bit_state_t               bit_state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [2:0]               bit_idx_r;
  logic [7:0]               shift_r;
  logic                     par_ok_r;

  pkt_state_t               pkt_state_r;
  logic [3:0]               ch_r;
  logic [IDX_W-1:0]         idx_r;
  logic [WORD_W-1:0]        stage_r;
  logic [GAP_W-1:0]         gap_r;
  logic [NUM_CH*WORD_W-1:0] freq_r;
  logic                     done_r;
  logic [3:0]               done_ch_r;
  logic                     frame_err_r;
  logic                     hdr_err_r;
  logic                     timeout_r;
  logic                     busy_r;

  logic                     stop_tick_s;
  logic                     byte_ok_s;
  logic                     byte_bad_s;
  logic                     hdr_ok_s;
  logic                     gap_run_s;
  logic [WORD_W-1:0]        commit_word_s;

  // Two-flop synchroniser for the asynchronous serial line, idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Bit FSM: deserialises one frame; returns to IDLE on the stop sample itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_state_r <= B_IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'd0;
      par_ok_r    <= 1'b1;
    end else begin
      case (bit_state_r)
        B_IDLE: begin
          cnt_r <= '0;
          if (!rx_sync_r) begin
            bit_state_r <= B_START;
          end else begin
            bit_state_r <= B_IDLE;
          end
        end
        B_START: begin
          if (cnt_r == HALF) begin
            cnt_r <= '0;
            if (!rx_sync_r) begin
              bit_idx_r   <= 3'd0;
              par_ok_r    <= 1'b1;
              bit_state_r <= B_DATA;
            end else begin
              bit_state_r <= B_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        B_DATA: begin
          if (cnt_r == DIV_M1) begin
            cnt_r     <= '0;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              bit_state_r <= (PARITY_EN != 0) ? B_PARITY : B_STOP;
            end else begin
              bit_state_r <= B_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        B_PARITY: begin
          if (cnt_r == DIV_M1) begin
            cnt_r       <= '0;
            par_ok_r    <= (rx_sync_r == parity_bit(shift_r, PARITY_ODD != 0));
            bit_state_r <= B_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        B_STOP: begin
          if (cnt_r == DIV_M1) begin
            cnt_r       <= '0;
            bit_state_r <= B_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r       <= '0;
          bit_state_r <= B_IDLE;
        end
      endcase
    end
  end

  // Byte-level events and packet decode helpers derived from the bit FSM.
  always_comb begin
    stop_tick_s = (bit_state_r == B_STOP) && (cnt_r == DIV_M1);
    if (stop_tick_s) begin
      byte_ok_s  = rx_sync_r && par_ok_r;
      byte_bad_s = !(rx_sync_r && par_ok_r);
    end else begin
      byte_ok_s  = 1'b0;
      byte_bad_s = 1'b0;
    end
    hdr_ok_s  = shift_r[7] && ({1'b0, shift_r[3:0]} < NUM_CH_L);
    gap_run_s = (bit_state_r == B_IDLE) && rx_sync_r;
    commit_word_s = stage_r;
    commit_word_s[32'(idx_r) * 8 +: 8] = shift_r;
  end

  // Packet FSM: header, data staging, atomic commit, abort on error/timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_state_r <= P_HDR;
      ch_r        <= 4'd0;
      idx_r       <= '0;
      stage_r     <= '0;
      gap_r       <= '0;
      freq_r      <= '0;
      done_r      <= 1'b0;
      done_ch_r   <= 4'd0;
      frame_err_r <= 1'b0;
      hdr_err_r   <= 1'b0;
      timeout_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      hdr_err_r   <= 1'b0;
      timeout_r   <= 1'b0;
      frame_err_r <= byte_bad_s;
      case (pkt_state_r)
        P_HDR: begin
          gap_r <= '0;
          if (byte_ok_s) begin
            if (hdr_ok_s) begin
              ch_r        <= shift_r[3:0];
              idx_r       <= '0;
              stage_r     <= '0;
              busy_r      <= 1'b1;
              pkt_state_r <= P_DATA;
            end else begin
              hdr_err_r <= 1'b1;
            end
          end else begin
            pkt_state_r <= P_HDR;
          end
        end
        P_DATA: begin
          if (byte_bad_s) begin
            gap_r       <= '0;
            busy_r      <= 1'b0;
            pkt_state_r <= P_HDR;
          end else if (byte_ok_s) begin
            gap_r <= '0;
            if (idx_r == LAST_IDX) begin
              freq_r[32'(ch_r) * WORD_W +: WORD_W] <= commit_word_s;
              done_r      <= 1'b1;
              done_ch_r   <= ch_r;
              busy_r      <= 1'b0;
              pkt_state_r <= P_HDR;
            end else begin
              stage_r <= commit_word_s;
              idx_r   <= idx_r + IDX_W'(1);
            end
          end else if (gap_run_s) begin
            if (gap_r == GAP_LAST) begin
              timeout_r   <= 1'b1;
              gap_r       <= '0;
              busy_r      <= 1'b0;
              pkt_state_r <= P_HDR;
            end else begin
              gap_r <= gap_r + GAP_W'(1);
            end
          end else begin
            gap_r <= '0;
          end
        end
        default: begin
          busy_r      <= 1'b0;
          pkt_state_r <= P_HDR;
        end
      endcase
    end
  end

  assign bus.freq      = freq_r;
  assign bus.done      = done_r;
  assign bus.done_ch   = done_ch_r;
  assign bus.frame_err = frame_err_r;
  assign bus.hdr_err   = hdr_err_r;
  assign bus.timeout   = timeout_r;
  assign bus.busy      = busy_r;
endmodule
